// File: rtl/serv_decode_pkg.sv
// serv_decode_pkg: shared opcode, CSR and immediate-format definitions
// for the SERV instruction decoder.
package serv_decode_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [1:0] CSEL_MSCRATCH = 2'b00;
  localparam logic [1:0] CSEL_MTVEC    = 2'b01;
  localparam logic [1:0] CSEL_MEPC     = 2'b10;
  localparam logic [1:0] CSEL_MTVAL    = 2'b11;

  typedef enum logic [3:0] {
    IMM_NONE = 4'd0,
    IMM_I    = 4'd1,
    IMM_S    = 4'd2,
    IMM_B    = 4'd3,
    IMM_U    = 4'd4,
    IMM_J    = 4'd5
  } imm_fmt_e;

  // Stored instruction fields; imm holds word bits [31:20]
  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
  } fields_t;

  // Which instruction slices feed the immediate:
  // [3]=31:25 [2]=24:20 [1]=19:12 [0]=11:7
  function automatic logic [3:0] imm_en_of(input imm_fmt_e f);
    logic [3:0] en;
    en = 4'b0000;
    unique case (f)
      IMM_I:        en = 4'b1100;
      IMM_S, IMM_B: en = 4'b1001;
      IMM_U, IMM_J: en = 4'b1110;
      default:      en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/serv_decode.sv
// serv_decode: RV32I(+M) decoder for the bit-serial SERV core.
// Fields are optionally registered, then decoded combinationally.
module serv_decode
  import serv_decode_pkg::*;
#(
  parameter int PRE_REGISTER = 1,
  parameter int MDU          = 0
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:2] i_wb_rdt,
  input  logic        i_wb_en,
  output logic        o_sh_right,
  output logic        o_bne_or_bge,
  output logic        o_cond_branch,
  output logic        o_e_op,
  output logic        o_ebreak,
  output logic        o_branch_op,
  output logic        o_shift_op,
  output logic        o_slt_or_branch,
  output logic        o_rd_op,
  output logic        o_two_stage_op,
  output logic        o_dbus_en,
  output logic        o_mdu_op,
  output logic [2:0]  o_ext_funct3,
  output logic        o_bufreg_rs1_en,
  output logic        o_bufreg_imm_en,
  output logic        o_bufreg_clr_lsb,
  output logic        o_bufreg_sh_signed,
  output logic        o_ctrl_jal_or_jalr,
  output logic        o_ctrl_utype,
  output logic        o_ctrl_pc_rel,
  output logic        o_ctrl_mret,
  output logic        o_alu_sub,
  output logic [1:0]  o_alu_bool_op,
  output logic        o_alu_cmp_eq,
  output logic        o_alu_cmp_sig,
  output logic [2:0]  o_alu_rd_sel,
  output logic        o_mem_signed,
  output logic        o_mem_word,
  output logic        o_mem_half,
  output logic        o_mem_cmd,
  output logic        o_csr_en,
  output logic [1:0]  o_csr_addr,
  output logic        o_csr_mstatus_en,
  output logic        o_csr_mie_en,
  output logic        o_csr_mcause_en,
  output logic [1:0]  o_csr_source,
  output logic        o_csr_d_sel,
  output logic        o_csr_imm_en,
  output logic        o_mtval_pc,
  output logic [3:0]  o_immdec_ctrl,
  output logic [3:0]  o_immdec_en,
  output logic        o_op_b_source,
  output logic        o_rd_mem_en,
  output logic        o_rd_csr_en,
  output logic        o_rd_alu_en,
  output logic [2:0]  funct3_out,
  output logic [4:0]  opcode_out,
  output logic        csr_op_out,
  output logic        csr_valid_out
);

  fields_t fld_new;
  fields_t fld;

  logic unused_rdt;
  assign unused_rdt = ^{i_wb_rdt[19:15], i_wb_rdt[11:7]};

  // Slice the raw word into the fields the decoder needs
  always_comb begin
    fld_new        = '0;
    fld_new.opcode = i_wb_rdt[6:2];
    fld_new.funct3 = i_wb_rdt[14:12];
    fld_new.imm    = i_wb_rdt[31:20];
  end

  if (PRE_REGISTER != 0) begin : g_reg
    fields_t fld_d;
    fields_t fld_q;

    // Load fields on a valid strobe, otherwise hold
    always_comb begin
      fld_d = fld_q;
      if (i_wb_en) fld_d = fld_new;
    end

    // Field register; reset forces an all-zero (LOAD) decode
    always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) fld_q <= '0;
      else       fld_q <= fld_d;
    end

    assign fld = fld_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, i_rst, i_wb_en};
    assign fld = fld_new;
  end

  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [11:0] ca;
  logic        is_ld, is_st, is_op, is_opi, is_br;
  logic        is_jal, is_jalr, is_lui, is_auipc, is_sys;
  logic        branch, alu_op, mdu_op, csr_op, f3_zero;
  logic        shift_op, slt_op, csr_hit;
  logic        hit_mstatus, hit_mie, hit_mcause;
  imm_fmt_e    fmt;

  assign opc = fld.opcode;
  assign f3  = fld.funct3;
  assign ca  = fld.imm;

  // Opcode class, CSR address match and immediate format
  always_comb begin
    is_ld    = opc == OPC_LOAD;
    is_st    = opc == OPC_STORE;
    is_op    = opc == OPC_OP;
    is_opi   = opc == OPC_OPIMM;
    is_br    = opc == OPC_BRANCH;
    is_jal   = opc == OPC_JAL;
    is_jalr  = opc == OPC_JALR;
    is_lui   = opc == OPC_LUI;
    is_auipc = opc == OPC_AUIPC;
    is_sys   = opc == OPC_SYSTEM;
    f3_zero  = f3 == 3'b000;
    branch   = opc[4] & ~opc[2];
    alu_op   = is_op | is_opi;
    mdu_op   = (MDU != 0) & is_op & ca[5];
    csr_op   = is_sys & ~f3_zero;
    shift_op = alu_op & (f3[1:0] == 2'b01) & ~mdu_op;
    slt_op   = alu_op & (f3[2:1] == 2'b01) & ~mdu_op;

    csr_hit     = 1'b0;
    hit_mstatus = 1'b0;
    hit_mie     = 1'b0;
    hit_mcause  = 1'b0;
    o_csr_addr  = CSEL_MSCRATCH;
    unique case (ca)
      CSR_MSTATUS:  begin csr_hit = 1'b1; hit_mstatus = 1'b1; end
      CSR_MIE:      begin csr_hit = 1'b1; hit_mie = 1'b1; end
      CSR_MCAUSE:   begin csr_hit = 1'b1; hit_mcause = 1'b1; end
      CSR_MSCRATCH: csr_hit = 1'b1;
      CSR_MTVEC:    begin csr_hit = 1'b1; o_csr_addr = CSEL_MTVEC; end
      CSR_MEPC:     begin csr_hit = 1'b1; o_csr_addr = CSEL_MEPC; end
      CSR_MTVAL:    begin csr_hit = 1'b1; o_csr_addr = CSEL_MTVAL; end
      default:      csr_hit = 1'b0;
    endcase

    fmt = IMM_NONE;
    unique case (1'b1)
      is_ld | is_opi | is_jalr: fmt = IMM_I;
      is_st:                    fmt = IMM_S;
      is_br:                    fmt = IMM_B;
      is_lui | is_auipc:        fmt = IMM_U;
      is_jal:                   fmt = IMM_J;
      default:                  fmt = IMM_NONE;
    endcase
  end

  // Control strobes for the serial datapath
  always_comb begin
    o_branch_op        = branch;
    o_cond_branch      = branch & ~opc[0];
    o_ctrl_jal_or_jalr = opc[4] & opc[0];
    o_ctrl_utype       = ~opc[4] & opc[2] & opc[0];
    o_ctrl_pc_rel      = is_auipc | is_jal | is_br;
    o_mtval_pc         = opc[4];

    o_e_op      = is_sys & f3_zero & ~ca[1];
    o_ebreak    = ca[0];
    o_ctrl_mret = is_sys & f3_zero & ca[1];
    o_csr_en    = csr_op;
    csr_op_out  = csr_op;

    csr_valid_out    = csr_op & csr_hit;
    o_csr_mstatus_en = csr_op & hit_mstatus;
    o_csr_mie_en     = csr_op & hit_mie;
    o_csr_mcause_en  = csr_op & hit_mcause;
    o_csr_source     = f3[1:0];
    o_csr_imm_en     = f3[2];
    o_csr_d_sel      = f3[2];

    o_dbus_en    = ~opc[4] & ~opc[2];
    o_mem_cmd    = opc[3];
    o_mem_signed = ~f3[2];
    o_mem_word   = f3[1];
    o_mem_half   = f3[0];

    o_alu_sub     = f3[1] | f3[0] | (opc[3] & ca[10]) | branch;
    o_alu_bool_op = f3[1:0];
    o_alu_cmp_eq  = f3[2:1] == 2'b00;
    o_alu_cmp_sig = ~((f3[0] & f3[1]) | (f3[1] & f3[2]));
    o_alu_rd_sel  = {f3[2], f3[2:1] == 2'b01, f3_zero};

    o_shift_op         = shift_op;
    o_sh_right         = f3[2];
    o_bufreg_sh_signed = ca[10];
    o_bne_or_bge       = f3[0];
    o_slt_or_branch    = branch | slt_op;
    o_op_b_source      = opc[3];

    o_mdu_op     = mdu_op;
    o_ext_funct3 = mdu_op ? f3 : 3'b000;

    o_two_stage_op = branch | (~opc[4] & ~opc[2])
                   | shift_op | slt_op | mdu_op;

    o_rd_op     = ~(is_st | is_br | (is_sys & f3_zero));
    o_rd_mem_en = is_ld;
    o_rd_csr_en = csr_op;
    o_rd_alu_en = alu_op & ~mdu_op;

    o_bufreg_rs1_en  = is_ld | is_st | alu_op | is_jalr | is_br;
    o_bufreg_imm_en  = is_ld | is_st | is_jal | is_jalr | is_br;
    o_bufreg_clr_lsb = is_jalr;

    o_immdec_ctrl = fmt;
    o_immdec_en   = imm_en_of(fmt);

    funct3_out = f3;
    opcode_out = opc;
  end

endmodule

// File: tb/tb_serv_decode.sv
// tb_serv_decode: random and directed checks of serv_decode against
// an instruction-level reference model.
module tb_serv_decode;

  localparam logic [4:0] L_LOAD   = 5'b00000;
  localparam logic [4:0] L_OPIMM  = 5'b00100;
  localparam logic [4:0] L_AUIPC  = 5'b00101;
  localparam logic [4:0] L_STORE  = 5'b01000;
  localparam logic [4:0] L_OP     = 5'b01100;
  localparam logic [4:0] L_LUI    = 5'b01101;
  localparam logic [4:0] L_BRANCH = 5'b11000;
  localparam logic [4:0] L_JALR   = 5'b11001;
  localparam logic [4:0] L_JAL    = 5'b11011;
  localparam logic [4:0] L_SYSTEM = 5'b11100;

  typedef struct packed {
    logic       sh_right, bne_or_bge, cond_branch, e_op, ebreak;
    logic       branch_op, shift_op, slt_or_branch, rd_op;
    logic       two_stage_op, dbus_en, mdu_op;
    logic [2:0] ext_funct3;
    logic       rs1_en, imm_en, clr_lsb, sh_signed;
    logic       jal_or_jalr, utype, pc_rel, mret, alu_sub;
    logic [1:0] bool_op;
    logic       cmp_eq, cmp_sig;
    logic [2:0] rd_sel;
    logic       mem_signed, mem_word, mem_half, mem_cmd, csr_en;
    logic [1:0] csr_addr;
    logic       mstatus_en, mie_en, mcause_en;
    logic [1:0] csr_source;
    logic       csr_d_sel, csr_imm_en, mtval_pc;
    logic [3:0] immdec_ctrl, immdec_en;
    logic       op_b_source, rd_mem_en, rd_csr_en, rd_alu_en;
    logic [2:0] funct3;
    logic [4:0] opcode;
    logic       csr_op, csr_valid;
  } dec_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:2] i_wb_rdt = '0;
  logic        i_wb_en = 1'b0;
  dec_t        r_act;
  dec_t        c_act;
  logic [31:0] held = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  serv_decode #(.PRE_REGISTER(1), .MDU(0)) u_reg (
    .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
    .o_sh_right(r_act.sh_right), .o_bne_or_bge(r_act.bne_or_bge),
    .o_cond_branch(r_act.cond_branch), .o_e_op(r_act.e_op),
    .o_ebreak(r_act.ebreak), .o_branch_op(r_act.branch_op),
    .o_shift_op(r_act.shift_op), .o_slt_or_branch(r_act.slt_or_branch),
    .o_rd_op(r_act.rd_op), .o_two_stage_op(r_act.two_stage_op),
    .o_dbus_en(r_act.dbus_en), .o_mdu_op(r_act.mdu_op),
    .o_ext_funct3(r_act.ext_funct3), .o_bufreg_rs1_en(r_act.rs1_en),
    .o_bufreg_imm_en(r_act.imm_en), .o_bufreg_clr_lsb(r_act.clr_lsb),
    .o_bufreg_sh_signed(r_act.sh_signed),
    .o_ctrl_jal_or_jalr(r_act.jal_or_jalr), .o_ctrl_utype(r_act.utype),
    .o_ctrl_pc_rel(r_act.pc_rel), .o_ctrl_mret(r_act.mret),
    .o_alu_sub(r_act.alu_sub), .o_alu_bool_op(r_act.bool_op),
    .o_alu_cmp_eq(r_act.cmp_eq), .o_alu_cmp_sig(r_act.cmp_sig),
    .o_alu_rd_sel(r_act.rd_sel), .o_mem_signed(r_act.mem_signed),
    .o_mem_word(r_act.mem_word), .o_mem_half(r_act.mem_half),
    .o_mem_cmd(r_act.mem_cmd), .o_csr_en(r_act.csr_en),
    .o_csr_addr(r_act.csr_addr), .o_csr_mstatus_en(r_act.mstatus_en),
    .o_csr_mie_en(r_act.mie_en), .o_csr_mcause_en(r_act.mcause_en),
    .o_csr_source(r_act.csr_source), .o_csr_d_sel(r_act.csr_d_sel),
    .o_csr_imm_en(r_act.csr_imm_en), .o_mtval_pc(r_act.mtval_pc),
    .o_immdec_ctrl(r_act.immdec_ctrl), .o_immdec_en(r_act.immdec_en),
    .o_op_b_source(r_act.op_b_source), .o_rd_mem_en(r_act.rd_mem_en),
    .o_rd_csr_en(r_act.rd_csr_en), .o_rd_alu_en(r_act.rd_alu_en),
    .funct3_out(r_act.funct3), .opcode_out(r_act.opcode),
    .csr_op_out(r_act.csr_op), .csr_valid_out(r_act.csr_valid)
  );

  serv_decode #(.PRE_REGISTER(0), .MDU(1)) u_comb (
    .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
    .o_sh_right(c_act.sh_right), .o_bne_or_bge(c_act.bne_or_bge),
    .o_cond_branch(c_act.cond_branch), .o_e_op(c_act.e_op),
    .o_ebreak(c_act.ebreak), .o_branch_op(c_act.branch_op),
    .o_shift_op(c_act.shift_op), .o_slt_or_branch(c_act.slt_or_branch),
    .o_rd_op(c_act.rd_op), .o_two_stage_op(c_act.two_stage_op),
    .o_dbus_en(c_act.dbus_en), .o_mdu_op(c_act.mdu_op),
    .o_ext_funct3(c_act.ext_funct3), .o_bufreg_rs1_en(c_act.rs1_en),
    .o_bufreg_imm_en(c_act.imm_en), .o_bufreg_clr_lsb(c_act.clr_lsb),
    .o_bufreg_sh_signed(c_act.sh_signed),
    .o_ctrl_jal_or_jalr(c_act.jal_or_jalr), .o_ctrl_utype(c_act.utype),
    .o_ctrl_pc_rel(c_act.pc_rel), .o_ctrl_mret(c_act.mret),
    .o_alu_sub(c_act.alu_sub), .o_alu_bool_op(c_act.bool_op),
    .o_alu_cmp_eq(c_act.cmp_eq), .o_alu_cmp_sig(c_act.cmp_sig),
    .o_alu_rd_sel(c_act.rd_sel), .o_mem_signed(c_act.mem_signed),
    .o_mem_word(c_act.mem_word), .o_mem_half(c_act.mem_half),
    .o_mem_cmd(c_act.mem_cmd), .o_csr_en(c_act.csr_en),
    .o_csr_addr(c_act.csr_addr), .o_csr_mstatus_en(c_act.mstatus_en),
    .o_csr_mie_en(c_act.mie_en), .o_csr_mcause_en(c_act.mcause_en),
    .o_csr_source(c_act.csr_source), .o_csr_d_sel(c_act.csr_d_sel),
    .o_csr_imm_en(c_act.csr_imm_en), .o_mtval_pc(c_act.mtval_pc),
    .o_immdec_ctrl(c_act.immdec_ctrl), .o_immdec_en(c_act.immdec_en),
    .o_op_b_source(c_act.op_b_source), .o_rd_mem_en(c_act.rd_mem_en),
    .o_rd_csr_en(c_act.rd_csr_en), .o_rd_alu_en(c_act.rd_alu_en),
    .funct3_out(c_act.funct3), .opcode_out(c_act.opcode),
    .csr_op_out(c_act.csr_op), .csr_valid_out(c_act.csr_valid)
  );

  task automatic check(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Instruction-level decode: classify the word, then apply each rule
  function automatic dec_t model(input logic [31:0] w, input bit mdu);
    dec_t d;
    logic [4:0] opc;
    logic [2:0] f3;
    logic [11:0] csr;
    logic [31:0] mask;
    bit ld, st, op, opi, br, jal, jalr, lui, auipc, sys;
    bit alu, m, jmp, slt, shf, cop;
    d = '0;
    opc = w[6:2];
    f3 = w[14:12];
    csr = w[31:20];
    ld = opc == L_LOAD;    st = opc == L_STORE;
    op = opc == L_OP;      opi = opc == L_OPIMM;
    br = opc == L_BRANCH;  jal = opc == L_JAL;
    jalr = opc == L_JALR;  lui = opc == L_LUI;
    auipc = opc == L_AUIPC; sys = opc == L_SYSTEM;
    alu = op || opi;
    m = mdu && op && w[25];
    jmp = br || jal || jalr;
    slt = alu && !m && (f3 == 3'd2 || f3 == 3'd3);
    shf = alu && !m && (f3 == 3'd1 || f3 == 3'd5);
    cop = sys && f3 != 3'd0;
    d.opcode = opc;
    d.funct3 = f3;
    d.branch_op = jmp;
    d.cond_branch = br;
    d.jal_or_jalr = jal || jalr;
    d.utype = lui || auipc;
    d.pc_rel = auipc || jal || br;
    d.mtval_pc = jmp || sys;
    d.e_op = sys && f3 == 3'd0 && !w[21];
    d.mret = sys && f3 == 3'd0 && w[21];
    d.ebreak = w[20];
    d.csr_op = cop;
    d.csr_en = cop;
    d.rd_csr_en = cop;
    d.csr_valid = cop && (csr == 12'h300 || csr == 12'h304 ||
      csr == 12'h342 || csr == 12'h340 || csr == 12'h305 ||
      csr == 12'h341 || csr == 12'h343);
    d.mstatus_en = cop && csr == 12'h300;
    d.mie_en = cop && csr == 12'h304;
    d.mcause_en = cop && csr == 12'h342;
    d.csr_addr = csr == 12'h305 ? 2'd1 : csr == 12'h341 ? 2'd2 :
                 csr == 12'h343 ? 2'd3 : 2'd0;
    d.csr_source = f3[1:0];
    d.csr_imm_en = f3[2];
    d.csr_d_sel = f3[2];
    d.dbus_en = ld || st;
    d.mem_cmd = w[5];
    d.mem_signed = !f3[2];
    d.mem_word = f3[1];
    d.mem_half = f3[0];
    d.alu_sub = f3 != 3'd0 && f3 != 3'd4 || (w[5] && w[30]) || jmp;
    d.bool_op = f3[1:0];
    d.cmp_eq = f3 < 3'd2;
    d.cmp_sig = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    d.rd_sel = {f3 >= 3'd4, f3 == 3'd2 || f3 == 3'd3, f3 == 3'd0};
    d.shift_op = shf;
    d.sh_right = f3[2];
    d.sh_signed = w[30];
    d.bne_or_bge = f3[0];
    d.slt_or_branch = jmp || slt;
    d.op_b_source = w[5];
    d.mdu_op = m;
    d.ext_funct3 = m ? f3 : 3'd0;
    d.two_stage_op = jmp || ld || st || shf || slt || m;
    d.rd_op = !(st || br || (sys && f3 == 3'd0));
    d.rd_mem_en = ld;
    d.rd_alu_en = alu && !m;
    d.rs1_en = ld || st || alu || jalr || br;
    d.imm_en = ld || st || jal || jalr || br;
    d.clr_lsb = jalr;
    mask = 32'h0;
    d.immdec_ctrl = 4'd0;
    if (ld || opi || jalr) begin d.immdec_ctrl = 4'd1; mask = 32'hFFF0_0000; end
    if (st) begin d.immdec_ctrl = 4'd2; mask = 32'hFE00_0F80; end
    if (br) begin d.immdec_ctrl = 4'd3; mask = 32'hFE00_0F80; end
    if (lui || auipc) begin d.immdec_ctrl = 4'd4; mask = 32'hFFFF_F000; end
    if (jal) begin d.immdec_ctrl = 4'd5; mask = 32'hFFFF_F000; end
    d.immdec_en = {|mask[31:25], |mask[24:20], |mask[19:12], |mask[11:7]};
    return d;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [4:0] opc;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: opc = L_LOAD;   1: opc = L_STORE;  2: opc = L_OP;
      3: opc = L_OPIMM;  4: opc = L_BRANCH; 5: opc = L_JAL;
      6: opc = L_JALR;   7: opc = L_LUI;    8: opc = L_AUIPC;
      default: opc = L_SYSTEM;
    endcase
    w[6:2] = opc;
    w[1:0] = 2'b11;
    if (opc == L_OP && $urandom_range(0, 1) == 0)
      w[31:25] = 7'b0000001;
    if (opc == L_SYSTEM && $urandom_range(0, 2) == 0)
      w[14:12] = 3'd0;
    if (opc == L_SYSTEM && $urandom_range(0, 3) != 0)
      case ($urandom_range(0, 6))
        0: w[31:20] = 12'h300; 1: w[31:20] = 12'h304;
        2: w[31:20] = 12'h305; 3: w[31:20] = 12'h340;
        4: w[31:20] = 12'h341; 5: w[31:20] = 12'h342;
        default: w[31:20] = 12'h343;
      endcase
    return w;
  endfunction

  task automatic step(input logic [31:0] w, input logic en);
    @(negedge clk);
    i_wb_rdt = w[31:2];
    i_wb_en = en;
    #1 check("comb", 128'(c_act), 128'(model(w, 1'b1)));
    @(posedge clk);
    #1;
    if (en) held = w;
    check("reg", 128'(r_act), 128'(model(held, 1'b0)));
  endtask

  initial begin
    #1 i_rst = 1'b1;
    i_wb_rdt = 30'(32'h12300093 >> 2);
    i_wb_en = 1'b1;
    #1;
    check("rst_state", 128'(r_act), 128'(model(32'h0, 1'b0)));
    check("rst_comb", 128'(c_act), 128'(model(32'h12300093, 1'b1)));
    @(negedge clk);
    i_rst = 1'b0;
    i_wb_en = 1'b0;
    held = '0;

    step(32'h12300093, 1'b1);
    check("addi_opc", 128'(r_act.opcode), 128'(5'b00100));
    check("addi_rd", 128'({r_act.rd_op, r_act.rd_alu_en}), 128'(2'b11));
    check("addi_sel", 128'(r_act.rd_sel), 128'(3'b001));
    check("addi_2st", 128'(r_act.two_stage_op), 128'(1'b0));

    step(32'h00000063, 1'b1);
    check("beq", 128'({r_act.branch_op, r_act.cond_branch, r_act.cmp_eq,
          r_act.rd_op, r_act.pc_rel}), 128'(5'b11101));

    step(32'h30200073, 1'b1);
    check("mret", 128'({r_act.mret, r_act.e_op, r_act.csr_op}),
          128'(3'b100));

    step(32'h0000A103, 1'b1);
    check("lw", 128'({r_act.dbus_en, r_act.mem_word, r_act.mem_cmd,
          r_act.rd_mem_en}), 128'(4'b1101));
    step(32'h12300093, 1'b0);
    check("lw_hold", 128'({r_act.opcode, r_act.funct3, r_act.dbus_en}),
          128'({5'b00000, 3'b010, 1'b1}));

    step(32'h340110F3, 1'b1);
    check("csrrw", 128'({r_act.csr_op, r_act.csr_valid, r_act.csr_addr}),
          128'(4'b1100));

    step(32'h023100B3, 1'b0);
    check("mul_mdu", 128'({c_act.mdu_op, c_act.ext_funct3}),
          128'(4'b1000));
    check("mul_nomdu", 128'(model(32'h023100B3, 1'b0).mdu_op),
          128'(r_act.mdu_op & 1'b0));

    // Asynchronous clear between edges, then reset beating a strobe
    @(negedge clk);
    #2 i_rst = 1'b1;
    #1;
    check("arst_opc", 128'(r_act.opcode), 128'(5'd0));
    check("arst_f3", 128'(r_act.funct3), 128'(3'd0));
    i_wb_rdt = 30'(32'h340110F3 >> 2);
    i_wb_en = 1'b1;
    @(posedge clk);
    #1;
    held = '0;
    check("rst_wins", 128'(r_act), 128'(model(32'h0, 1'b0)));
    @(negedge clk);
    i_rst = 1'b0;
    i_wb_en = 1'b0;

    for (int i = 0; i < 400; i++)
      step(rand_word(), 1'($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_decode.md
SERV_DECODE -- requirements
Module: serv_decode

Interface
REQ-001 SHALL have parameter PRE_REGISTER, default 1; 1 registers the instruction fields, 0 makes decode purely combinational.
REQ-002 SHALL have parameter MDU, default 0; 1 enables M-extension decode.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_wb_rdt, input, [31:2]: instruction word from the ibus.
REQ-006 SHALL have port i_wb_en, input, 1 bit: instruction-valid strobe.
REQ-007 SHALL have these 1-bit outputs for control and state: o_sh_right, o_bne_or_bge, o_cond_branch, o_e_op, o_ebreak, o_branch_op, o_shift_op, o_slt_or_branch, o_rd_op, o_two_stage_op, o_dbus_en, o_mdu_op.
REQ-008 SHALL have outputs o_ext_funct3 [2:0], o_bufreg_rs1_en, o_bufreg_imm_en, o_bufreg_clr_lsb and o_bufreg_sh_signed.
REQ-009 SHALL have outputs o_ctrl_jal_or_jalr, o_ctrl_utype, o_ctrl_pc_rel, o_ctrl_mret, o_alu_sub, o_alu_bool_op [1:0], o_alu_cmp_eq, o_alu_cmp_sig and o_alu_rd_sel [2:0].
REQ-010 SHALL have outputs o_mem_signed, o_mem_word, o_mem_half, o_mem_cmd, o_csr_en, o_csr_addr [1:0], o_csr_mstatus_en, o_csr_mie_en, o_csr_mcause_en, o_csr_source [1:0], o_csr_d_sel, o_csr_imm_en and o_mtval_pc.
REQ-011 SHALL have outputs o_immdec_ctrl [3:0], o_immdec_en [3:0], o_op_b_source, o_rd_mem_en, o_rd_csr_en and o_rd_alu_en.
REQ-012 SHALL have debug outputs funct3_out [2:0], opcode_out [4:0], csr_op_out and csr_valid_out.

Function
REQ-013 SHALL extract the following fields from i_wb_rdt:
- opcode = [6:2]
- funct3 = [14:12]
- op20, op21, op22, op26
- imm25 = [25]
- imm30 = [30]
REQ-014 With PRE_REGISTER=1, SHALL capture the fields on a rising clk edge when i_wb_en=1, hold them otherwise, and present the decode one cycle later.
REQ-015 With PRE_REGISTER=0, all outputs SHALL be combinational from i_wb_rdt, and i_wb_en and i_rst SHALL have no effect.
REQ-016 Branch/jump decode SHALL be:
- o_branch_op = opcode[4]&~opcode[2]
- o_cond_branch = branch&~opcode[0]
- o_ctrl_jal_or_jalr = opcode[4]&opcode[0]
- o_ctrl_utype = ~opcode[4]&opcode[2]&opcode[0]
- o_ctrl_pc_rel = AUIPC|JAL|BRANCH
- o_mtval_pc = opcode[4]
REQ-017 SYSTEM decode (opcode 11100) SHALL be:
- o_e_op = SYSTEM & funct3==0 & ~op21
- o_ebreak = op20
- o_ctrl_mret = SYSTEM & funct3==0 & op21
- csr_op_out = o_csr_en = SYSTEM & funct3!=0
REQ-018 csr_valid_out SHALL be csr_op & CSR address in {mstatus, mie, mcause, mscratch, mtvec, mepc, mtval}.
REQ-019 CSR controls SHALL be:
- o_csr_addr: 00 mscratch, 01 mtvec, 10 mepc, 11 mtval
- o_csr_mstatus_en, o_csr_mie_en and o_csr_mcause_en set for the matching CSR
- o_csr_source = funct3[1:0]
- o_csr_imm_en = funct3[2]
- o_csr_d_sel = funct3[2]
REQ-020 Memory decode SHALL be:
- o_dbus_en = ~opcode[4]&~opcode[2]
- o_mem_cmd = opcode[3]
- o_mem_signed = ~funct3[2]
- o_mem_word = funct3[1]
- o_mem_half = funct3[0]
REQ-021 ALU decode SHALL be:
- o_alu_sub = funct3[1]|funct3[0]|(opcode[3]&imm30)|branch
- o_alu_bool_op = funct3[1:0]
- o_alu_cmp_eq = funct3[2:1]==00
- o_alu_cmp_sig = ~((funct3[0]&funct3[1])|(funct3[1]&funct3[2]))
- o_alu_rd_sel = {funct3[2], funct3==010|011, funct3==000}
REQ-022 Shift, compare and operand-B decode SHALL be:
- o_shift_op = OP/OP-IMM & funct3[1:0]==01 & ~mdu
- o_sh_right = funct3[2]
- o_bufreg_sh_signed = imm30
- o_bne_or_bge = funct3[0]
- o_slt_or_branch = branch | OP/OP-IMM SLT/SLTU
- o_op_b_source = opcode[3]
REQ-023 o_mdu_op SHALL be MDU & opcode==01100 & imm25, and o_ext_funct3 SHALL be funct3 when o_mdu_op=1, else 0.
REQ-024 o_two_stage_op SHALL be set for branch, jump, load/store, shift, SLT and mdu instructions.
REQ-025 Destination-register decode SHALL be:
- o_rd_op = 0 for STORE, BRANCH and SYSTEM with funct3==0; 1 otherwise
- o_rd_mem_en = LOAD
- o_rd_csr_en = csr_op
- o_rd_alu_en = OP/OP-IMM & ~mdu
REQ-026 o_bufreg_rs1_en SHALL be set for LOAD, STORE, OP, OP-IMM, JALR and BRANCH.
REQ-027 o_bufreg_imm_en SHALL be set for LOAD, STORE, JAL, JALR and BRANCH, and o_bufreg_clr_lsb SHALL be set for JALR.
REQ-028 o_immdec_ctrl and o_immdec_en SHALL select the I/S/B/U/J immediate format from opcode for the serial immediate decoder.
REQ-029 funct3_out SHALL equal funct3 and opcode_out SHALL equal opcode.

Reset
REQ-030 With PRE_REGISTER=1, i_rst=1 SHALL asynchronously clear all stored fields to 0, so the outputs decode as all-zero fields (opcode 00000, LOAD).
REQ-031 When reset and i_wb_en=1 coincide, reset SHALL win.

Structure
REQ-032 Opcode constants (LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM) and the CSR address codes SHALL live in a shared package.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 0x12300093 (ADDI) with i_wb_en=1 -> next cycle opcode_out=00100, o_rd_op=1, o_rd_alu_en=1, o_alu_rd_sel=001, o_two_stage_op=0.
REQ-035 0x00000063 (BEQ) -> o_branch_op=1, o_cond_branch=1, o_alu_cmp_eq=1, o_rd_op=0, o_ctrl_pc_rel=1.
REQ-036 0x30200073 (MRET) -> o_ctrl_mret=1, o_e_op=0, csr_op_out=0.
REQ-037 0x0000A103 (LW) -> o_dbus_en=1, o_mem_word=1, o_mem_cmd=0, o_rd_mem_en=1; then i_wb_en=0 with a new word -> outputs hold.
REQ-038 0x340110F3 (CSRRW mscratch) -> csr_op_out=1, csr_valid_out=1, o_csr_addr=00; with MDU=1, 0x023100B3 (MUL) -> o_mdu_op=1, o_ext_funct3=000.
REQ-039 i_rst pulsed mid-stream -> opcode_out=0 and funct3_out=0 immediately, with no clock edge needed.
